down_timer: RTL and testbench
=============================

# down_timer

Loadable down-counting timer with a prescaler, start/stop control, optional auto-reload, and a one-cycle terminal-count pulse. It is the decrementing counterpart of the team's loadable up-counter. Software or an FSM loads a reload value and starts the timer. Downstream logic consumes `done` as a periodic or one-shot event and may sample `cnt` at any time. The block is single clock domain, posedge only.

## Interface
- `WIDTH`, default 8: width of the reload value and the count.
- `PRE_WIDTH`, default 4: width of the prescaler divisor.
- `clk` in, 1 bit: clock, rising edge.
- `rst` in, 1 bit: reset, asynchronous, active-high.
- `cen` in, 1 bit: tick enable; each high cycle advances the prescaler.
- `wen` in, 1 bit: write enable for the reload register.
- `dat` in, WIDTH bits: reload value written on `wen`.
- `pre` in, PRE_WIDTH bits: prescale divisor minus 1. One decrement occurs per (`pre`+1) `cen` cycles. Sampled on `start` and on every reload.
- `auto` in, 1 bit: auto-reload mode. Sampled on `start`.
- `start` in, 1 bit: load `cnt` from the reload register and run.
- `stop` in, 1 bit: halt and hold `cnt`.
- `cnt` out, WIDTH bits: current count, registered.
- `busy` out, 1 bit: high in RUN.
- `done` out, 1 bit: one-cycle pulse when `cnt` reaches 0.

## Operation
- Reset values: reload register 0, `cnt` 0, prescaler 0, latched `pre` 0, latched `auto` 0, `busy` 0, `done` 0, state IDLE.
- The reload register is written on `wen` in any state. In IDLE, `wen` also loads `cnt` with `dat`. In RUN, `wen` does not touch `cnt`; the new value takes effect at the next reload or start.
- Control priority per cycle: `stop` > `start` > tick. `wen` is independent of this priority.
- A tick is a cycle in RUN with `cen`=1 and prescaler == latched `pre`. On a tick the prescaler clears. On a non-tick cycle with `cen`=1 the prescaler increments. With `cen`=0 the prescaler holds.
- States:
  - IDLE: `busy`=0. On `start`, latch `pre` and `auto`, load `cnt` from the reload register, clear the prescaler, and go to RUN. If the reload value is 0, stay in IDLE instead, leave `cnt`=0, and pulse `done` next cycle.
  - RUN: `busy`=1. On a tick with `cnt` > 1, `cnt` decrements by 1. On a tick with `cnt` == 1, `cnt` becomes 0 and `done` pulses.
    - If latched `auto`=1, the next tick reloads `cnt` from the reload register and re-latches `pre`; the state stays RUN. If the reload value is 0, go to IDLE.
    - If latched `auto`=0, go to IDLE after the `cnt` = 0 transition; `cnt` stays 0.
  - `start` in RUN restarts: reload `cnt`, clear the prescaler, re-latch `pre` and `auto`.
  - `stop` in RUN returns to IDLE and holds `cnt` and the prescaler value. A later `start` reloads; there is no resume.
- Arithmetic: the decrement is WIDTH-bit and never underflows, because `cnt` == 0 is never decremented. Period in auto mode is (reload+1)·(`pre`+1) `cen` cycles: the reload value decrements plus one reload tick.
- `rst` mid-run forces all outputs to their reset values immediately, independent of `clk`. The reload register is cleared as well.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `start` sampled at edge n: `busy`=1 and `cnt`=reload are visible after edge n.
- First decrement: with `cen` held high, it lands (`pre`+1) edges after the start edge.
- `done` is high for exactly one cycle, the same cycle in which `cnt` first shows 0. It never stays high for two consecutive cycles.
- `busy` falls in the same cycle `done` rises when `auto`=0. In auto mode `busy` stays high throughout.
- A `stop` and a tick in the same cycle: `stop` wins. `cnt` is not decremented and `done` does not pulse.
- A `start` and the final tick in the same cycle: `start` wins, `cnt` is reloaded, and `done` does not pulse.

## Structure
- The shared package holds the state enum (IDLE, RUN) and a `TIMER_STATE_W` constant.
- One sub-module is natural: `timer_prescaler`, a PRE_WIDTH counter with `clr`, `en`, and `div` inputs and a `tick` output.
- The top level holds the reload register, count register, FSM, and `done` register.

## Test plan
- Reset and load: assert `rst`, then `wen` with `dat`=5. Expect `cnt`=0, `busy`=0, `done`=0 during reset, and `cnt`=5 one cycle after the write (IDLE).
- One-shot: reload=3, `pre`=0, `auto`=0, `cen`=1, pulse `start`. Expect `cnt` 3,2,1,0 on successive cycles, `done` high only with `cnt`=0, then `busy`=0 and `cnt` held at 0.
- Prescale plus gaps: reload=2, `pre`=2, `cen` toggling 1,0,1,0,… Expect each decrement after 3 `cen`-high cycles (6 clocks) and `done` after 12 clocks.
- Auto-reload: reload=2, `pre`=0, `auto`=1. Expect `cnt` 2,1,0,2,1,0,…, `done` every 3 cycles, and `busy` constantly 1. Write `dat`=4 mid-run; the next period reloads 4.
- Collisions: `stop` on the tick where `cnt`=1 leaves `cnt`=1, no `done`, state IDLE. `start` on the final tick reloads with no `done`. `start` with reload=0 gives a one-cycle `done` and `busy`=0.
- Async reset mid-run: reload=200, `rst` asserted between clock edges. Expect `cnt`, `busy`, and `done` at 0 immediately, and no `done` after release.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: FSM state encoding and width.
package down_timer_pkg;

    localparam int TIMER_STATE_W = 1;

    typedef enum logic [TIMER_STATE_W-1:0] {
        TS_IDLE = 1'b0,
        TS_RUN  = 1'b1
    } timer_state_e;

    localparam logic [TIMER_STATE_W-1:0] ST_IDLE = TS_IDLE;
    localparam logic [TIMER_STATE_W-1:0] ST_RUN  = TS_RUN;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for down_timer: counts enabled cycles and flags a tick when the
// count matches the divisor, clearing itself on that tick.
module timer_prescaler #(
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [PRE_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [PRE_WIDTH-1:0] r_cnt;
    logic                 w_tick;

    assign w_tick = i_en && (r_cnt == i_div);
    assign o_tick = w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, start/stop, optional
// auto-reload and a one-cycle terminal-count pulse.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cen,
    input  logic                 i_wen,
    input  logic [WIDTH-1:0]     i_dat,
    input  logic [PRE_WIDTH-1:0] i_pre,
    input  logic                 i_auto,
    input  logic                 i_start,
    input  logic                 i_stop,
    output logic [WIDTH-1:0]     o_cnt,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [TIMER_STATE_W-1:0] r_state;
    logic [WIDTH-1:0]         r_reload;
    logic [WIDTH-1:0]         r_cnt;
    logic [PRE_WIDTH-1:0]     r_pre;
    logic                     r_auto;
    logic                     r_done;

    logic w_run;
    logic w_ps_en;
    logic w_ps_clr;
    logic w_tick;

    assign w_run = (r_state == ST_RUN);
    // stop and start both pre-empt the tick, so the prescaler must not advance
    assign w_ps_en  = w_run && i_cen && !i_stop && !i_start;
    assign w_ps_clr = i_start && !i_stop;

    timer_prescaler #(
        .PRE_WIDTH(PRE_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_ps_clr),
        .i_en   (w_ps_en),
        .i_div  (r_pre),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_reload <= '0;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_auto   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_wen) begin
                r_reload <= i_dat;
            end

            if (!i_stop && i_start) begin
                // start from either state; a zero reload finishes immediately
                r_pre  <= i_pre;
                r_auto <= i_auto;
                r_cnt  <= r_reload;
                if (r_reload == '0) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ST_RUN;
                end
            end else if (!w_run) begin
                if (!i_stop && i_wen) begin
                    r_cnt <= i_dat;
                end
            end else if (i_stop) begin
                r_state <= ST_IDLE;
            end else if (w_tick) begin
                if (r_cnt > ONE) begin
                    r_cnt <= r_cnt - ONE;
                end else if (r_cnt == ONE) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                    if (!r_auto) begin
                        r_state <= ST_IDLE;
                    end
                end else begin
                    // cnt already 0 in auto mode: this tick is the reload tick
                    r_cnt <= r_reload;
                    r_pre <= i_pre;
                    if (r_reload == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = w_run;
    assign o_done = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: each step pushes the expected outputs for
// the coming edge and pops/compares them just after that edge.
module tb_down_timer;

    localparam int WIDTH     = 8;
    localparam int PRE_WIDTH = 4;

    logic                 clk;
    logic                 rst;
    logic                 i_cen;
    logic                 i_wen;
    logic [WIDTH-1:0]     i_dat;
    logic [PRE_WIDTH-1:0] i_pre;
    logic                 i_auto;
    logic                 i_start;
    logic                 i_stop;
    logic [WIDTH-1:0]     o_cnt;
    logic                 o_busy;
    logic                 o_done;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    down_timer #(
        .WIDTH     (WIDTH),
        .PRE_WIDTH (PRE_WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_cen   (i_cen),
        .i_wen   (i_wen),
        .i_dat   (i_dat),
        .i_pre   (i_pre),
        .i_auto  (i_auto),
        .i_start (i_start),
        .i_stop  (i_stop),
        .o_cnt   (o_cnt),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input int c, input bit b, input bit d);
        exp_t e;
        e.cnt  = WIDTH'(c);
        e.busy = b;
        e.done = d;
        sb_q.push_back(e);
    endtask

    // advance one edge, then compare the DUT against the oldest expectation
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        check_val({tag, "_sbq"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("txn %-10s cnt=%0d busy=%0d done=%0d (exp %0d/%0d/%0d)",
                     tag, o_cnt, o_busy, o_done, e.cnt, e.busy, e.done);
            check_val({tag, "_cnt"},  int'(o_cnt),  int'(e.cnt));
            check_val({tag, "_busy"}, int'(o_busy), int'(e.busy));
            check_val({tag, "_done"}, int'(o_done), int'(e.done));
        end
    endtask

    task automatic cyc(input string tag, input int c, input bit b, input bit d);
        expect_out(c, b, d);
        step(tag);
    endtask

    initial begin
        rst = 1'b1;
        i_cen = 1'b0; i_wen = 1'b0; i_dat = '0; i_pre = '0;
        i_auto = 1'b0; i_start = 1'b0; i_stop = 1'b0;

        // reset and load
        #1;
        check_val("rst_cnt",  int'(o_cnt),  0);
        check_val("rst_busy", int'(o_busy), 0);
        check_val("rst_done", int'(o_done), 0);
        i_wen = 1'b1; i_dat = 8'd5;
        cyc("in_rst", 0, 0, 0);
        rst = 1'b0;
        cyc("load5", 5, 0, 0);
        i_wen = 1'b0;

        // one-shot, reload 3, pre 0
        i_wen = 1'b1; i_dat = 8'd3;
        cyc("load3", 3, 0, 0);
        i_wen = 1'b0;
        i_pre = 4'd0; i_auto = 1'b0; i_cen = 1'b1; i_start = 1'b1;
        cyc("os_start", 3, 1, 0);
        i_start = 1'b0;
        cyc("os_2", 2, 1, 0);
        cyc("os_1", 1, 1, 0);
        cyc("os_0", 0, 0, 1);
        cyc("os_hold", 0, 0, 0);
        cyc("os_hold", 0, 0, 0);

        // prescale 3 with cen high every other clock
        i_cen = 1'b0;
        i_wen = 1'b1; i_dat = 8'd2;
        cyc("load2", 2, 0, 0);
        i_wen = 1'b0;
        i_pre = 4'd2; i_start = 1'b1;
        cyc("ps_start", 2, 1, 0);
        i_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            i_cen = (k % 2 == 0);
            if (k < 6)       cyc("ps_run", 2, 1, 0);
            else if (k < 12) cyc("ps_run", 1, 1, 0);
            else             cyc("ps_done", 0, 0, 1);
        end
        i_cen = 1'b0;
        cyc("ps_idle", 0, 0, 0);

        // auto-reload, reload 2 then 4 written mid-run
        i_wen = 1'b1; i_dat = 8'd2;
        cyc("load2", 2, 0, 0);
        i_wen = 1'b0;
        i_pre = 4'd0; i_auto = 1'b1; i_cen = 1'b1; i_start = 1'b1;
        cyc("ar_start", 2, 1, 0);
        i_start = 1'b0;
        cyc("ar_1", 1, 1, 0);
        cyc("ar_0", 0, 1, 1);
        cyc("ar_rl", 2, 1, 0);
        i_wen = 1'b1; i_dat = 8'd4;
        cyc("ar_1w", 1, 1, 0);
        i_wen = 1'b0;
        cyc("ar_0", 0, 1, 1);
        cyc("ar_rl4", 4, 1, 0);
        cyc("ar_3", 3, 1, 0);
        cyc("ar_2", 2, 1, 0);
        cyc("ar_1", 1, 1, 0);
        cyc("ar_0", 0, 1, 1);
        cyc("ar_rl4", 4, 1, 0);
        i_stop = 1'b1;
        cyc("ar_stop", 4, 0, 0);
        i_stop = 1'b0;

        // stop collides with the tick at cnt=1
        i_auto = 1'b0; i_start = 1'b1;
        cyc("cs_start", 4, 1, 0);
        i_start = 1'b0;
        cyc("cs_3", 3, 1, 0);
        cyc("cs_2", 2, 1, 0);
        cyc("cs_1", 1, 1, 0);
        i_stop = 1'b1;
        cyc("cs_stop", 1, 0, 0);
        i_stop = 1'b0;
        cyc("cs_hold", 1, 0, 0);

        // start collides with the final tick
        i_wen = 1'b1; i_dat = 8'd2;
        cyc("load2", 2, 0, 0);
        i_wen = 1'b0; i_start = 1'b1;
        cyc("cst_start", 2, 1, 0);
        i_start = 1'b0;
        cyc("cst_1", 1, 1, 0);
        i_start = 1'b1;
        cyc("cst_restart", 2, 1, 0);
        i_start = 1'b0;
        cyc("cst_1", 1, 1, 0);
        cyc("cst_0", 0, 0, 1);

        // start with zero reload
        i_wen = 1'b1; i_dat = 8'd0;
        cyc("load0", 0, 0, 0);
        i_wen = 1'b0; i_start = 1'b1;
        cyc("z_start", 0, 0, 1);
        i_start = 1'b0;
        cyc("z_after", 0, 0, 0);

        // asynchronous reset mid-run
        i_wen = 1'b1; i_dat = 8'd200;
        cyc("load200", 200, 0, 0);
        i_wen = 1'b0; i_start = 1'b1;
        cyc("ar2_start", 200, 1, 0);
        i_start = 1'b0;
        cyc("ar2_199", 199, 1, 0);
        cyc("ar2_198", 198, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_cnt",  int'(o_cnt),  0);
        check_val("arst_busy", int'(o_busy), 0);
        check_val("arst_done", int'(o_done), 0);
        #1;
        rst = 1'b0;
        cyc("post_rst", 0, 0, 0);
        cyc("post_rst", 0, 0, 0);
        cyc("post_rst", 0, 0, 0);
        // reload register was cleared too, so a start finishes at once
        i_start = 1'b1;
        cyc("post_start", 0, 0, 1);
        i_start = 1'b0;
        cyc("post_idle", 0, 0, 0);

        check_val("sbq_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
